// File: rtl/avst_latency_matcher_if.sv
// Avalon-ST beat bundle: qualifiers, channel, payload and the ready back-pressure.
interface avst_latency_matcher_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 2
);
  logic              valid;
  logic              sop;
  logic              eop;
  logic [CH_W-1:0]   channel;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, sop, eop, channel, data, input ready);
  modport slave  (input valid, sop, eop, channel, data, output ready);
endinterface

// File: rtl/avst_latency_matcher.sv
// Stall-aware, run-time programmable delay line keeping Avalon-ST sideband aligned with a DSP core.
// state | meaning
// RUN   | accepting beats, line advances whenever downstream allows
// DRAIN | latency change pending: input closed, in-flight beats flushed
// LOAD  | one cycle: new latency applied, stale stages cleared
module avst_latency_matcher #(
  parameter int DATA_W        = 32,
  parameter int CH_W          = 2,
  parameter int MAX_DEPTH     = 16,
  parameter int RESET_LATENCY = 5,
  parameter int STALL_MODE    = 1,
  parameter int DEPTH_W       = $clog2(MAX_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  avst_latency_matcher_if.slave  snk,
  avst_latency_matcher_if.master src,
  input  logic [DEPTH_W-1:0]     cfg_latency,
  input  logic                   cfg_load,
  input  logic                   err_clear,
  output logic [DEPTH_W-1:0]     occupancy,
  output logic [DEPTH_W-1:0]     lat_active,
  output logic                   cfg_clamped,
  output logic                   err_framing,
  output logic                   busy
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} state_t;

  typedef struct packed {
    logic              valid;
    logic              sop;
    logic              eop;
    logic [CH_W-1:0]   channel;
    logic [DATA_W-1:0] data;
  } beat_t;

  state_t             state, state_nxt;
  beat_t              stage [MAX_DEPTH];
  beat_t              tap;
  logic [DEPTH_W-1:0] lat_q, req_q, cfg_sat;
  logic               cfg_oor, advance, accept, release_beat, in_pkt;

  always_comb begin
    cfg_oor = 1'b0;
    cfg_sat = cfg_latency;
    if (cfg_latency == '0) begin
      cfg_sat = DEPTH_W'(1);
      cfg_oor = 1'b1;
    end else if (cfg_latency > DEPTH_W'(MAX_DEPTH)) begin
      cfg_sat = DEPTH_W'(MAX_DEPTH);
      cfg_oor = 1'b1;
    end
  end

  always_comb begin
    tap = stage[0];
    for (int k = 0; k < MAX_DEPTH; k++)
      if (lat_q == DEPTH_W'(k + 1)) tap = stage[k];
  end

  assign src.valid    = tap.valid;
  assign src.sop      = tap.sop;
  assign src.eop      = tap.eop;
  assign src.channel  = tap.channel;
  assign src.data     = tap.data;

  assign advance      = (STALL_MODE == 0) || src.ready || !tap.valid;
  assign snk.ready    = advance && (state == RUN) && rst_n;
  assign accept       = snk.valid && snk.ready;
  assign release_beat = tap.valid && advance;
  assign busy         = (state != RUN);
  assign lat_active   = lat_q;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cfg_load) state_nxt = DRAIN;
      DRAIN:   if (occupancy == '0) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;

  // Stages past the old tap still hold already-delivered beats; LOAD wipes them
  // so a longer latency cannot replay them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_DEPTH; k++) stage[k] <= '0;
    end else if (state == LOAD) begin
      for (int k = 0; k < MAX_DEPTH; k++) stage[k] <= '0;
    end else if (advance) begin
      stage[0] <= '{valid: accept, sop: snk.sop && accept, eop: snk.eop && accept,
                    channel: snk.channel, data: snk.data};
      for (int k = 1; k < MAX_DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         occupancy <= '0;
    else if (accept && !release_beat)   occupancy <= occupancy + DEPTH_W'(1);
    else if (!accept && release_beat)   occupancy <= occupancy - DEPTH_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q       <= DEPTH_W'(RESET_LATENCY);
      req_q       <= DEPTH_W'(RESET_LATENCY);
      cfg_clamped <= 1'b0;
    end else begin
      if (cfg_load) begin
        req_q       <= cfg_sat;
        cfg_clamped <= cfg_oor;
      end
      if (state == LOAD) lat_q <= cfg_load ? cfg_sat : req_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt      <= 1'b0;
      err_framing <= 1'b0;
    end else begin
      if (accept) begin
        if (snk.sop && !snk.eop) in_pkt <= 1'b1;
        else if (snk.eop)        in_pkt <= 1'b0;
      end
      if (err_clear)                          err_framing <= 1'b0;
      else if (accept && (snk.sop == in_pkt)) err_framing <= 1'b1;
    end
  end
endmodule

// File: tb/tb_avst_latency_matcher.sv
// Bench for avst_latency_matcher: queue/timestamp reference model plus directed literal checks.
module tb_avst_latency_matcher;
  localparam int DATA_W  = 32;
  localparam int CH_W    = 2;
  localparam int DEPTH_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avst_latency_matcher_if #(.DATA_W(DATA_W), .CH_W(CH_W)) snk ();
  avst_latency_matcher_if #(.DATA_W(DATA_W), .CH_W(CH_W)) src ();
  avst_latency_matcher_if #(.DATA_W(DATA_W), .CH_W(CH_W)) snk1 ();
  avst_latency_matcher_if #(.DATA_W(DATA_W), .CH_W(CH_W)) src1 ();

  logic [DEPTH_W-1:0] cfg_latency, occupancy, lat_active, cfg_lat1, occ1, lat1;
  logic cfg_load, err_clear, cfg_clamped, err_framing, busy;
  logic cfg_load1, err_clear1, clamp1, err1, busy1;

  avst_latency_matcher #(.STALL_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .snk(snk), .src(src),
    .cfg_latency(cfg_latency), .cfg_load(cfg_load), .err_clear(err_clear),
    .occupancy(occupancy), .lat_active(lat_active), .cfg_clamped(cfg_clamped),
    .err_framing(err_framing), .busy(busy));

  avst_latency_matcher #(.STALL_MODE(0)) dut_free (
    .clk(clk), .rst_n(rst_n), .snk(snk1), .src(src1),
    .cfg_latency(cfg_lat1), .cfg_load(cfg_load1), .err_clear(err_clear1),
    .occupancy(occ1), .lat_active(lat1), .cfg_clamped(clamp1),
    .err_framing(err1), .busy(busy1));

  // Reference: each accepted beat is stamped with the advance count at acceptance;
  // it is presented once exactly lat advancing cycles have elapsed.
  typedef struct {
    logic        sop;
    logic        eop;
    logic [1:0]  ch;
    logic [31:0] d;
    longint      t;
  } mbeat_t;

  mbeat_t q[$];
  longint adv_cnt;
  int     m_lat, m_state, m_req;
  logic   m_clamp, m_err, m_inpkt;
  int     n_chk = 0, n_fail = 0, hs_cnt = 0;

  int          occ_max, lat_meas, b, hs0, seen, n;
  logic [11:0] vseen;
  logic [31:0] d5, d8;
  logic        s5, e8;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    adv_cnt = 0;
    m_lat   = 5;
    m_req   = 5;
    m_state = 0;
    m_clamp = 1'b0;
    m_err   = 1'b0;
    m_inpkt = 1'b0;
  endtask

  function automatic logic exp_valid();
    return (q.size() != 0) && (adv_cnt - q[0].t == longint'(m_lat));
  endfunction

  function automatic int clampv(input int v);
    return (v == 0) ? 1 : ((v > 16) ? 16 : v);
  endfunction

  task automatic compare();
    logic ev;
    ev = exp_valid();
    chk("out_valid", src.valid, ev);
    if (ev) begin
      chk("out_data", src.data, q[0].d);
      chk("out_channel", src.channel, q[0].ch);
    end
    chk("out_sop", src.sop, ev ? q[0].sop : 1'b0);
    chk("out_eop", src.eop, ev ? q[0].eop : 1'b0);
    chk("in_ready", snk.ready, rst_n && (src.ready || !ev) && (m_state == 0));
    chk("occupancy", occupancy, q.size());
    chk("lat_active", lat_active, m_lat);
    chk("busy", busy, m_state != 0);
    chk("cfg_clamped", cfg_clamped, m_clamp);
    chk("err_framing", err_framing, m_err);
    if (rst_n && src.valid && src.ready) hs_cnt++;
  endtask

  task automatic m_update();
    logic   ev, adv, acc;
    int     occ0, c;
    mbeat_t bt;
    ev   = exp_valid();
    adv  = src.ready || !ev;
    acc  = snk.valid && adv && (m_state == 0);
    occ0 = q.size();
    if (ev && adv) void'(q.pop_front());
    if (acc) begin
      bt.sop = snk.sop; bt.eop = snk.eop; bt.ch = snk.channel; bt.d = snk.data; bt.t = adv_cnt;
      q.push_back(bt);
    end
    if (adv) adv_cnt++;
    if (err_clear) m_err = 1'b0;
    else if (acc && ((snk.sop && m_inpkt) || (!snk.sop && !m_inpkt))) m_err = 1'b1;
    if (acc) begin
      if (snk.sop && !snk.eop) m_inpkt = 1'b1;
      else if (snk.eop)        m_inpkt = 1'b0;
    end
    c = clampv(int'(cfg_latency));
    if (cfg_load) m_clamp = (cfg_latency == 0) || (cfg_latency > 16);
    case (m_state)
      0: if (cfg_load) begin m_req = c; m_state = 1; end
      1: begin
        if (cfg_load) m_req = c;
        if (occ0 == 0) m_state = 2;
      end
      default: begin
        m_lat   = cfg_load ? c : m_req;
        m_state = 0;
      end
    endcase
  endtask

  task automatic nedge();
    @(negedge clk);
    compare();
  endtask

  task automatic pedge();
    @(posedge clk);
    if (rst_n) m_update();
    #1;
  endtask

  task automatic cyc();
    nedge();
    pedge();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin cyc(); k++; end
    chk("idle_timeout", k < 200, 1'b1);
  endtask

  task automatic load_lat(input int v);
    wait_idle();
    cfg_latency = DEPTH_W'(v);
    cfg_load    = 1'b1;
    cyc();
    cfg_load    = 1'b0;
    wait_idle();
  endtask

  initial begin
    snk.valid = 0; snk.sop = 0; snk.eop = 0; snk.channel = '0; snk.data = '0; src.ready = 1;
    snk1.valid = 0; snk1.sop = 0; snk1.eop = 0; snk1.channel = '0; snk1.data = '0; src1.ready = 0;
    cfg_latency = '0; cfg_load = 0; err_clear = 0;
    cfg_lat1 = '0; cfg_load1 = 0; err_clear1 = 0;
    m_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // T1: four beats back to back at latency 5
    occ_max = 0;
    for (int i = 0; i < 12; i++) begin
      snk.valid = (i < 4); snk.sop = (i == 0); snk.eop = (i == 3);
      snk.data = 32'hA000_0000 + 32'(i); snk.channel = 2'(i);
      nedge();
      vseen[i] = src.valid;
      if (i == 5) begin d5 = src.data; s5 = src.sop; end
      if (i == 8) begin d8 = src.data; e8 = src.eop; end
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      pedge();
    end
    snk.valid = 0; snk.sop = 0; snk.eop = 0;
    chk("t1_valid_window", vseen, 12'h1E0);
    chk("t1_first_data", d5, 32'hA000_0000);
    chk("t1_first_sop", s5, 1'b1);
    chk("t1_last_data", d8, 32'hA000_0003);
    chk("t1_last_eop", e8, 1'b1);
    chk("t1_occ_peak", occ_max, 4);

    // T4: clamping of out-of-range latencies
    load_lat(0);
    chk("t4_lat_zero", lat_active, 1);
    chk("t4_clamp_zero", cfg_clamped, 1'b1);
    load_lat(20);
    chk("t4_lat_big", lat_active, 16);
    chk("t4_clamp_big", cfg_clamped, 1'b1);
    load_lat(7);
    chk("t4_lat_ok", lat_active, 7);
    chk("t4_clamp_ok", cfg_clamped, 1'b0);

    // T2: downstream stall in cycles 6..8 at latency 4
    load_lat(4);
    hs0 = hs_cnt; b = 0;
    for (int i = 0; i < 30; i++) begin
      snk.valid = (b < 12); snk.sop = 1; snk.eop = 1;
      snk.data = 32'hB000_0000 + 32'(b); snk.channel = 2'(b);
      src.ready = !(i >= 6 && i <= 8);
      nedge();
      if (i >= 6 && i <= 8) chk("t2_in_ready_stall", snk.ready, 1'b0);
      if (snk.valid && snk.ready) b++;
      pedge();
    end
    snk.valid = 0; src.ready = 1;
    chk("t2_beats_out", hs_cnt - hs0, 12);

    // T3: latency change to 9 with three beats in flight
    for (int i = 0; i < 5; i++) begin
      snk.valid = (i < 3); snk.sop = 1; snk.eop = 1; snk.data = 32'hC000_0000 + 32'(i);
      cfg_latency = 5'd9; cfg_load = (i == 3);
      nedge();
      if (i == 4) chk("t3_in_ready_drain", snk.ready, 1'b0);
      pedge();
    end
    cfg_load = 0; snk.valid = 0;
    wait_idle();
    chk("t3_lat_nine", lat_active, 9);
    lat_meas = -1;
    for (int i = 0; i < 30; i++) begin
      snk.valid = (i == 0); snk.data = 32'hC0DE_0009;
      nedge();
      if (src.valid && lat_meas < 0) lat_meas = i;
      pedge();
    end
    chk("t3_new_latency", lat_meas, 9);

    // T5: sop, sop, eop raises framing error; err_clear drops it
    for (int i = 0; i < 4; i++) begin
      snk.valid = (i < 3); snk.sop = (i < 2); snk.eop = (i == 2); snk.data = 32'hD000_0000 + 32'(i);
      nedge();
      if (i == 1) chk("t5_err_before", err_framing, 1'b0);
      if (i == 2) chk("t5_err_after", err_framing, 1'b1);
      pedge();
    end
    snk.valid = 0; snk.sop = 0; snk.eop = 0;
    err_clear = 1; cyc(); err_clear = 0;
    chk("t5_err_cleared", err_framing, 1'b0);

    // Random traffic, stalls, latency reloads and error clears against the model
    for (int i = 0; i < 3000; i++) begin
      snk.valid   = 1'($urandom_range(0, 1));
      snk.sop     = ($urandom_range(0, 2) == 0);
      snk.eop     = ($urandom_range(0, 2) == 0);
      snk.channel = 2'($urandom);
      snk.data    = $urandom;
      src.ready   = ($urandom_range(0, 9) < 7);
      cfg_load    = ($urandom_range(0, 99) == 0);
      cfg_latency = DEPTH_W'($urandom_range(0, 20));
      err_clear   = ($urandom_range(0, 49) == 0);
      cyc();
    end
    snk.valid = 0; cfg_load = 0; err_clear = 0; src.ready = 1;
    repeat (20) cyc();

    // T6: reset with four beats in flight
    load_lat(5);
    for (int i = 0; i < 4; i++) begin
      snk.valid = 1; snk.sop = 1; snk.eop = 1; snk.data = 32'hF000_0000 + 32'(i);
      cyc();
    end
    snk.valid = 0;
    chk("t6_occ_before", occupancy, 4);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("t6_valid_rst", src.valid, 1'b0);
    chk("t6_occ_rst", occupancy, 0);
    chk("t6_ready_rst", snk.ready, 1'b0);
    chk("t6_data_rst", src.data, 32'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      nedge();
      if (src.valid) seen++;
      pedge();
    end
    chk("t6_no_replay", seen, 0);
    chk("t6_lat_reset", lat_active, 5);

    // Free-running instance ignores out_ready=0
    lat_meas = -1; n = 0;
    for (int i = 0; i < 15; i++) begin
      snk1.valid = (i == 0); snk1.sop = 1; snk1.eop = 1; snk1.data = 32'h0000_00E1;
      nedge();
      if (i == 0) chk("sm0_in_ready", snk1.ready, 1'b1);
      if (src1.valid) begin
        if (lat_meas < 0) lat_meas = i;
        n++;
        chk("sm0_data", src1.data, 32'h0000_00E1);
      end
      pedge();
    end
    chk("sm0_latency", lat_meas, 5);
    chk("sm0_single_cycle", n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
